// File: rtl/urv_dm_wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// urv_dm_wb_bridge_pkg
// Shared definitions for the uRV data-memory to Wishbone bridge:
//   - bridge FSM state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   - Wishbone address/data/select widths
//   - helper that word-aligns a byte address for the bus
// -----------------------------------------------------------------------------
package urv_dm_wb_bridge_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte lanes are selected by wb_sel, so the bus only ever sees word addresses.
  function automatic logic [WB_ADR_W-1:0] wb_align(input logic [WB_ADR_W-1:0] addr);
    return {addr[WB_ADR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/urv_bus_timeout.sv
// -----------------------------------------------------------------------------
// urv_bus_timeout
// Loadable saturating up-counter used as a bus-cycle watchdog. The counter
// stops at g_timeout and expired_o stays high while it sits there.
//
// Ports:
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset (count -> 0)
//   clr_i       synchronous clear (highest priority)
//   load_i      synchronous load of load_val_i
//   load_val_i  value loaded when load_i=1
//   en_i        count enable (saturates at g_timeout)
//   expired_o   count == g_timeout
// -----------------------------------------------------------------------------
module urv_bus_timeout #(
  parameter int unsigned g_timeout = 255,
  parameter int unsigned CNT_W     = $clog2(g_timeout + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(g_timeout);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= load_val_i;
    end else if (en_i && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired_o = (count == LIMIT);

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// -----------------------------------------------------------------------------
// urv_dm_wb_bridge
// Turns single uRV data-memory load/store requests into one pipelined
// Wishbone (B4) master cycle each, returns load data and one-cycle completion
// pulses, and forces completion on bus error or watchdog expiry.
//
// Parameters:
//   g_timeout   cycles from REQ entry to forced completion (2..65535)
//   g_err_data  load data returned on bus error or timeout
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   dm_addr_i             CPU byte address
//   dm_data_s_i           CPU store data
//   dm_data_select_i      CPU byte enables
//   dm_load_i/dm_store_i  request strobes (store wins if both)
//   dm_ready_o            bridge idle and able to accept a request
//   dm_data_l_o           load data, held until the next load completes
//   dm_load_done_o        one-cycle load completion pulse
//   dm_store_done_o       one-cycle store completion pulse
//   wb_*                  Wishbone B4 pipelined master port
//   bus_err_o             one-cycle pulse on bus error or timeout
//   bus_err_addr_o        request address of the last failed access
// -----------------------------------------------------------------------------
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int unsigned    g_timeout  = 255,
  parameter logic [31:0]    g_err_data = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [WB_ADR_W-1:0] dm_addr_i,
  input  logic [WB_DAT_W-1:0] dm_data_s_i,
  input  logic [WB_SEL_W-1:0] dm_data_select_i,
  input  logic                dm_load_i,
  input  logic                dm_store_i,
  output logic                dm_ready_o,
  output logic [WB_DAT_W-1:0] dm_data_l_o,
  output logic                dm_load_done_o,
  output logic                dm_store_done_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_stall_i,
  output logic                bus_err_o,
  output logic [WB_ADR_W-1:0] bus_err_addr_o
);

  localparam int unsigned CNT_W = $clog2(g_timeout + 1);

  state_t              state;
  logic [WB_ADR_W-1:0] req_addr;

  logic accept;
  logic busy;
  logic bus_resp;
  logic tmo_expired;
  logic tmo_hit;
  logic finish;
  logic fail;

  assign accept = (state == ST_IDLE) && (dm_load_i || dm_store_i);
  assign busy   = (state == ST_REQ) || (state == ST_WAIT);

  // A response only counts once the strobe has been taken by the slave:
  // in REQ that means stall is low in the same cycle.
  assign bus_resp = (((state == ST_REQ) && !wb_stall_i) || (state == ST_WAIT)) &&
                    (wb_ack_i || wb_err_i);

  // The watchdog only forces completion when the slave did not answer in
  // this same cycle; a genuine response takes precedence.
  assign tmo_hit = busy && tmo_expired && !bus_resp;
  assign finish  = bus_resp || tmo_hit;
  assign fail    = (bus_resp && wb_err_i) || tmo_hit;

  // Loaded with 1 on acceptance so that the count equals the number of
  // cycles spent in REQ/WAIT; expiry at g_timeout completes on the next edge.
  urv_bus_timeout #(
    .g_timeout (g_timeout),
    .CNT_W     (CNT_W)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      ((state == ST_IDLE) && !accept),
    .load_i     (accept),
    .load_val_i (CNT_W'(1)),
    .en_i       (busy),
    .expired_o  (tmo_expired)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      req_addr        <= '0;
      dm_ready_o      <= 1'b1;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_we_o         <= 1'b0;
      wb_adr_o        <= '0;
      wb_sel_o        <= '0;
      wb_dat_o        <= '0;
      bus_err_o       <= 1'b0;
      bus_err_addr_o  <= '0;
    end else begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      bus_err_o       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_REQ;
            dm_ready_o <= 1'b0;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_we_o    <= dm_store_i;
            wb_adr_o   <= wb_align(dm_addr_i);
            wb_sel_o   <= dm_data_select_i;
            wb_dat_o   <= dm_data_s_i;
            req_addr   <= dm_addr_i;
          end
        end

        ST_REQ, ST_WAIT: begin
          if (finish) begin
            state           <= ST_DONE;
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            dm_load_done_o  <= !wb_we_o;
            dm_store_done_o <= wb_we_o;
            if (!wb_we_o) begin
              dm_data_l_o <= fail ? g_err_data : wb_dat_i;
            end
            if (fail) begin
              bus_err_o      <= 1'b1;
              bus_err_addr_o <= req_addr;
            end
          end else if ((state == ST_REQ) && !wb_stall_i) begin
            state    <= ST_WAIT;
            wb_stb_o <= 1'b0;
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          dm_ready_o <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
